// File: rtl/bullet_pkg.sv
// Shared types and default geometry for the bullet engine.
package bullet_pkg;
    typedef enum logic {B_IDLE = 1'b0, B_FLY = 1'b1} slot_state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int SPR_W_DEF  = 6;
    localparam int SPR_H_DEF  = 6;
    localparam int CORNER_DEF = 2;
    localparam int SPEED_DEF  = 4;
endpackage

// File: rtl/bullet_sprite.sv
// Rounded-square sprite mask: lit when (sx,sy) is inside the box and not in a clipped corner.
module bullet_sprite
    import bullet_pkg::*;
#(
    parameter int SPR_W  = SPR_W_DEF,
    parameter int SPR_H  = SPR_H_DEF,
    parameter int CORNER = CORNER_DEF,
    parameter int SX_W   = 11,
    parameter int SY_W   = 11
) (
    input  logic signed [SX_W-1:0] sx,
    input  logic signed [SY_W-1:0] sy,
    output logic                   lit
);
    localparam logic signed [SX_W-1:0] WM1 = SX_W'(SPR_W - 1);
    localparam logic signed [SY_W-1:0] HM1 = SY_W'(SPR_H - 1);
    localparam logic signed [SX_W-1:0] ZX  = '0;
    localparam logic signed [SY_W-1:0] ZY  = '0;

    logic signed [SX_W-1:0] rx, mx;
    logic signed [SY_W-1:0] ry, my;
    logic                   in_rng;

    // rx/ry are the distances to the far edges; both non-negative means inside the box
    always_comb begin
        rx     = WM1 - sx;
        ry     = HM1 - sy;
        mx     = (sx < rx) ? sx : rx;
        my     = (sy < ry) ? sy : ry;
        in_rng = (sx >= ZX) && (rx >= ZX) && (sy >= ZY) && (ry >= ZY);
        lit    = in_rng && ((int'(mx) + int'(my)) >= CORNER);
    end
endmodule

// File: rtl/bullet_pool.sv
// Multi-slot bullet engine: spawn, per-frame motion, retire, and pixel coverage queries.
// Optional BULLET_POOL_HIT_IDX_EN adds pix_idx (lowest-index slot covering the pixel).
module bullet_pool
    import bullet_pkg::*;
#(
    parameter int N_BULLETS = 4,
    parameter int X_W       = 10,
    parameter int Y_W       = 10,
    parameter int SPR_W     = SPR_W_DEF,
    parameter int SPR_H     = SPR_H_DEF,
    parameter int CORNER    = CORNER_DEF,
    parameter int SPEED     = SPEED_DEF,
    parameter int SCREEN_H  = 480,
    parameter int IW        = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_tick,
    input  logic                 fire,
    input  logic [X_W-1:0]       fire_x,
    input  logic [Y_W-1:0]       fire_y,
    input  logic                 fire_dir,
    output logic                 fire_ack,
    output logic                 fire_drop,
    input  logic                 kill,
    input  logic [IW-1:0]        kill_idx,
    input  logic [X_W-1:0]       pix_x,
    input  logic [Y_W-1:0]       pix_y,
    output logic                 pix_on,
`ifdef BULLET_POOL_HIT_IDX_EN
    output logic [IW-1:0]        pix_idx,
`endif
    output logic [N_BULLETS-1:0] active_mask
);
    localparam logic signed [Y_W:0] YMAX = (Y_W+1)'(SCREEN_H - SPR_H);
    localparam logic signed [Y_W:0] SPD  = (Y_W+1)'(SPEED);
    localparam logic signed [Y_W:0] ZY   = '0;

    slot_state_t          state    [N_BULLETS];
    slot_state_t          state_nx [N_BULLETS];
    logic [X_W-1:0]       x_r      [N_BULLETS];
    logic [Y_W-1:0]       y_r      [N_BULLETS];
    logic                 dir_r    [N_BULLETS];
    logic signed [Y_W:0]  y_mv     [N_BULLETS];
    logic signed [X_W:0]  sx       [N_BULLETS];
    logic signed [Y_W:0]  sy       [N_BULLETS];
    logic [N_BULLETS-1:0] idle, sel, exits, kill_hit, lit, hit;
    logic                 fire_ok, accept, found;

    // Fire arbitration: lowest-index IDLE slot, legal spawn y only
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < N_BULLETS; i++) begin
            idle[i] = (state[i] == B_IDLE);
            if (idle[i] && !found) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
        fire_ok = (signed'({1'b0, fire_y}) <= YMAX);
        accept  = fire && fire_ok && found;
    end

    // Motion in Y_W+1 signed bits so an upward exit is seen as negative, not a wrap
    always_comb begin
        for (int i = 0; i < N_BULLETS; i++) begin
            y_mv[i]     = (dir_r[i] == DIR_DOWN) ? (signed'({1'b0, y_r[i]}) + SPD)
                                                 : (signed'({1'b0, y_r[i]}) - SPD);
            exits[i]    = (y_mv[i] < ZY) || (y_mv[i] > YMAX);
            kill_hit[i] = kill && (kill_idx == IW'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < N_BULLETS; i++) begin
            state_nx[i] = state[i];
            case (state[i])
                B_IDLE:  if (accept && sel[i]) state_nx[i] = B_FLY;
                B_FLY:   if (kill_hit[i] || (frame_tick && exits[i])) state_nx[i] = B_IDLE;
                default: state_nx[i] = B_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_BULLETS; i++) state[i] <= B_IDLE;
        end else begin
            for (int i = 0; i < N_BULLETS; i++) state[i] <= state_nx[i];
        end
    end

    always_comb begin
        for (int i = 0; i < N_BULLETS; i++) active_mask[i] = (state[i] == B_FLY);
    end

    // A freshly loaded slot was IDLE, so the frame_tick update cannot touch it this cycle
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_BULLETS; i++) begin
            if (accept && sel[i]) begin
                x_r[i]   <= fire_x;
                y_r[i]   <= fire_y;
                dir_r[i] <= fire_dir;
            end else if (frame_tick && (state[i] == B_FLY) && !kill_hit[i] && !exits[i]) begin
                y_r[i] <= y_mv[i][Y_W-1:0];
            end
        end
    end

    for (genvar g = 0; g < N_BULLETS; g++) begin : g_slot
        assign sx[g] = signed'({1'b0, pix_x}) - signed'({1'b0, x_r[g]});
        assign sy[g] = signed'({1'b0, pix_y}) - signed'({1'b0, y_r[g]});

        bullet_sprite #(
            .SPR_W  (SPR_W),
            .SPR_H  (SPR_H),
            .CORNER (CORNER),
            .SX_W   (X_W + 1),
            .SY_W   (Y_W + 1)
        ) u_sprite (
            .sx  (sx[g]),
            .sy  (sy[g]),
            .lit (lit[g])
        );

        assign hit[g] = (state[g] == B_FLY) && lit[g];
    end

`ifdef BULLET_POOL_HIT_IDX_EN
    function automatic logic [IW-1:0] first_hit(input logic [N_BULLETS-1:0] h);
        first_hit = '0;
        for (int i = N_BULLETS - 1; i >= 0; i--) begin
            if (h[i]) first_hit = IW'(i);
        end
    endfunction
`endif

    // Output register stage: handshake pulses and query result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fire_ack  <= 1'b0;
            fire_drop <= 1'b0;
            pix_on    <= 1'b0;
`ifdef BULLET_POOL_HIT_IDX_EN
            pix_idx   <= '0;
`endif
        end else begin
            fire_ack  <= accept;
            fire_drop <= fire && !accept;
            pix_on    <= |hit;
`ifdef BULLET_POOL_HIT_IDX_EN
            pix_idx   <= first_hit(hit);
`endif
        end
    end
endmodule

// File: tb/tb_bullet_pool.sv
// Self-checking bench for bullet_pool: directed scenarios plus randomized traffic against a slot model.
module tb_bullet_pool;
    localparam int N     = 4;
    localparam int YMAX  = 474;
    localparam int SPEED = 4;

    logic       clk = 1'b0;
    logic       rst, frame_tick, fire, fire_dir, kill;
    logic [9:0] fire_x, fire_y, pix_x, pix_y;
    logic [1:0] kill_idx;
    logic       fire_ack, fire_drop, pix_on;
    logic [3:0] active_mask;
`ifdef BULLET_POOL_HIT_IDX_EN
    logic [1:0] pix_idx;
`endif

    always #5 clk = ~clk;

    bullet_pool dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .fire        (fire),
        .fire_x      (fire_x),
        .fire_y      (fire_y),
        .fire_dir    (fire_dir),
        .fire_ack    (fire_ack),
        .fire_drop   (fire_drop),
        .kill        (kill),
        .kill_idx    (kill_idx),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_on      (pix_on),
`ifdef BULLET_POOL_HIT_IDX_EN
        .pix_idx     (pix_idx),
`endif
        .active_mask (active_mask)
    );

    int checks = 0;
    int errors = 0;

    bit m_live [N];
    int m_x    [N];
    int m_y    [N];
    bit m_dir  [N];
    bit n_live [N];
    int n_x    [N];
    int n_y    [N];
    bit n_dir  [N];
    int e_ack, e_drop, e_on, e_idx, e_mask;

    function automatic bit sprite_lit(int sx, int sy);
        int a, b;
        if (sx < 0 || sx >= 6 || sy < 0 || sy >= 6) return 1'b0;
        a = (sx < 5 - sx) ? sx : 5 - sx;
        b = (sy < 5 - sy) ? sy : 5 - sy;
        return (a + b) >= 2;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        int free;
        free   = -1;
        e_on   = 0;
        e_idx  = 0;
        e_ack  = 0;
        e_drop = 0;
        for (int i = 0; i < N; i++) begin
            if (m_live[i] && sprite_lit(int'(pix_x) - m_x[i], int'(pix_y) - m_y[i])) begin
                if (e_on == 0) e_idx = i;
                e_on = 1;
            end
            n_live[i] = m_live[i];
            n_x[i]    = m_x[i];
            n_y[i]    = m_y[i];
            n_dir[i]  = m_dir[i];
            if (!m_live[i] && free < 0) free = i;
        end
        for (int i = 0; i < N; i++) begin
            int ny;
            if (m_live[i]) begin
                if (kill && int'(kill_idx) == i) begin
                    n_live[i] = 1'b0;
                end else if (frame_tick) begin
                    ny = m_dir[i] ? m_y[i] + SPEED : m_y[i] - SPEED;
                    if (ny < 0 || ny > YMAX) n_live[i] = 1'b0;
                    else n_y[i] = ny;
                end
            end
        end
        if (fire) begin
            if (int'(fire_y) <= YMAX && free >= 0) begin
                n_live[free] = 1'b1;
                n_x[free]    = int'(fire_x);
                n_y[free]    = int'(fire_y);
                n_dir[free]  = fire_dir;
                e_ack        = 1;
            end else begin
                e_drop = 1;
            end
        end
        e_mask = 0;
        for (int i = 0; i < N; i++) if (n_live[i]) e_mask = e_mask | (1 << i);
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        #1;
        chk("fire_ack", fire_ack, e_ack);
        chk("fire_drop", fire_drop, e_drop);
        chk("active_mask", active_mask, e_mask);
        chk("pix_on", pix_on, e_on);
`ifdef BULLET_POOL_HIT_IDX_EN
        chk("pix_idx", pix_idx, e_idx);
`endif
        for (int i = 0; i < N; i++) begin
            m_live[i] = n_live[i];
            m_x[i]    = n_x[i];
            m_y[i]    = n_y[i];
            m_dir[i]  = n_dir[i];
        end
        fire       = 1'b0;
        kill       = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_now_ack", fire_ack, 0);
        chk("rst_now_drop", fire_drop, 0);
        chk("rst_now_pix_on", pix_on, 0);
        chk("rst_now_mask", active_mask, 0);
`ifdef BULLET_POOL_HIT_IDX_EN
        chk("rst_now_pix_idx", pix_idx, 0);
`endif
        for (int i = 0; i < N; i++) m_live[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_mask", active_mask, 0);
        chk("rst_hold_pix_on", pix_on, 0);
        chk("rst_hold_ack", fire_ack, 0);
        rst = 1'b0;
    endtask

    task automatic fire_at(int x, int y, bit d);
        fire     = 1'b1;
        fire_x   = 10'(x);
        fire_y   = 10'(y);
        fire_dir = d;
        tick();
    endtask

    task automatic query(int x, int y);
        pix_x = 10'(x);
        pix_y = 10'(y);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; frame_tick = 1'b0; fire = 1'b0; fire_dir = 1'b0; kill = 1'b0;
        fire_x = '0; fire_y = '0; pix_x = 10'd1000; pix_y = 10'd1000; kill_idx = '0;
        #2;
        do_reset();

        // Reset then first spawn, and sprite shape
        fire_at(100, 200, 0);
        chk("t1_ack", fire_ack, 1);
        chk("t1_mask", active_mask, 1);
        query(100, 200); chk("t2_corner", pix_on, 0);
        query(102, 200); chk("t2_top_edge", pix_on, 1);
        query(101, 201); chk("t2_inner", pix_on, 1);
        query(106, 203); chk("t2_outside", pix_on, 0);

        // Full pool, then refill of a killed slot
        pix_x = 10'd1000; pix_y = 10'd1000;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            fire_at(20 + 10 * k, 100, 0);
            chk("t3_ack", fire_ack, (k < 4) ? 1 : 0);
            chk("t3_drop", fire_drop, (k == 4) ? 1 : 0);
        end
        kill = 1'b1; kill_idx = 2'd2;
        tick();
        chk("t3_killed_mask", active_mask, 4'b1011);
        fire_at(77, 88, 1);
        chk("t3_refill_ack", fire_ack, 1);
        chk("t3_refill_mask", active_mask, 4'b1111);
        chk("t3_model_slot2_x", m_x[2], 77);
        query(79, 88); chk("t3_refill_hit", pix_on, 1);

        // Screen exits
        pix_x = 10'd1000; pix_y = 10'd1000;
        do_reset();
        fire_at(200, 6, 0);
        frame_tick = 1'b1;
        tick();
        chk("t4_model_y", m_y[0], 2);
        chk("t4_still_live", active_mask, 1);
        query(202, 2); chk("t4_moved_hit", pix_on, 1);
        frame_tick = 1'b1;
        tick();
        chk("t4_exit_up", active_mask, 0);
        fire_at(200, 472, 1);
        chk("t4_ack_472", fire_ack, 1);
        frame_tick = 1'b1;
        tick();
        chk("t4_exit_down", active_mask, 0);
        fire_at(10, 475, 0);
        chk("t4_illegal_drop", fire_drop, 1);
        fire_at(10, 474, 1);
        chk("t4_edge_ack", fire_ack, 1);

        // Simultaneous events
        pix_x = 10'd1000; pix_y = 10'd1000;
        do_reset();
        fire_at(100, 100, 1);
        fire_at(200, 200, 1);
        fire_at(300, 300, 1);
        frame_tick = 1'b1; kill = 1'b1; kill_idx = 2'd1;
        tick();
        chk("t5_kill_tick_mask", active_mask, 4'b0101);
        chk("t5_model_y0", m_y[0], 104);
        query(102, 104); chk("t5_moved_hit", pix_on, 1);
        frame_tick = 1'b1;
        fire_at(150, 50, 0);
        chk("t5_fire_tick_ack", fire_ack, 1);
        chk("t5_fire_tick_mask", active_mask, 4'b0111);
        query(152, 50); chk("t5_unmoved_hit", pix_on, 1);
        do_reset();

`ifdef BULLET_POOL_HIT_IDX_EN
        // Hit priority and reset during a query
        fire_at(300, 100, 0);
        fire_at(48, 48, 0);
        fire_at(300, 300, 0);
        fire_at(48, 48, 1);
        query(50, 50);
        chk("t6_on", pix_on, 1);
        chk("t6_idx", pix_idx, 1);
        kill = 1'b1; kill_idx = 2'd1;
        tick();
        query(50, 50);
        chk("t6_idx_after_kill", pix_idx, 3);
        do_reset();
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            if ($urandom_range(0, 3) == 0) begin
                fire     = 1'b1;
                fire_x   = 10'($urandom_range(0, 1000));
                fire_y   = 10'($urandom_range(0, 479));
                fire_dir = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 7) == 0) begin
                kill     = 1'b1;
                kill_idx = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 15) == 0) frame_tick = 1'b1;
            if ($urandom_range(0, 1) == 0) begin
                int j;
                j     = $urandom_range(0, N - 1);
                pix_x = 10'(m_x[j] + int'($urandom_range(0, 7)) - 1);
                pix_y = 10'(m_y[j] + int'($urandom_range(0, 7)) - 1);
            end else begin
                pix_x = 10'($urandom_range(0, 1023));
                pix_y = 10'($urandom_range(0, 1023));
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
